// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle arithmetic/logic ops, start pulses, optional iterative divider.
// Define ALU_PIPE_DIV_EN to build the restoring divider and its DIV state.
module alu_pipe #(
   parameter int DATA_W = 19,
   parameter int OPC_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero_flag,
   output logic              divided_by_0,
   output logic              overflow_a,
   output logic              overflow_s,
   output logic              overflow_m,
   output logic              fft_strt,
   output logic              crypto_en
);

   localparam int MSB = DATA_W - 1;

   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_DIV = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_AND = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_NOT = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_INC = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_DEC = OPC_W'(9);
   localparam logic [OPC_W-1:0] OP_FFT = OPC_W'(24);
   localparam logic [OPC_W-1:0] OP_ENC = OPC_W'(25);
   localparam logic [OPC_W-1:0] OP_DCR = OPC_W'(26);

   typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

   state_t state_q, state_d;

   logic                accept;
   logic [DATA_W-1:0]   res_c;
   logic                dz_c, oa_c, os_c, om_c, zero_c;
   logic [2*DATA_W-1:0] prod;
   logic                div_go;
   logic                div_done;
   logic [DATA_W-1:0]   div_q_nxt;

   assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign prod     = {{DATA_W{1'b0}}, operand_a} * {{DATA_W{1'b0}}, operand_b};

   // Single-cycle datapath; a nonzero divide only raises div_go and is resolved by the divider
   always_comb begin
      res_c = '0;
      dz_c  = 1'b0;
      oa_c  = 1'b0;
      os_c  = 1'b0;
      om_c  = 1'b0;
`ifdef ALU_PIPE_DIV_EN
      div_go = 1'b0;
`endif
      case (opcode)
         OP_ADD: begin
            res_c = operand_a + operand_b;
            oa_c  = (operand_a[MSB] == operand_b[MSB]) && (res_c[MSB] != operand_a[MSB]);
         end
         OP_SUB: begin
            res_c = operand_a - operand_b;
            os_c  = (operand_a[MSB] != operand_b[MSB]) && (res_c[MSB] != operand_a[MSB]);
         end
         OP_MUL: begin
            res_c = prod[DATA_W-1:0];
            om_c  = |prod[2*DATA_W-1:DATA_W];
         end
         OP_DIV: begin
            if (operand_b == '0) begin
               res_c = '1;
               dz_c  = 1'b1;
            end
`ifdef ALU_PIPE_DIV_EN
            else begin
               div_go = 1'b1;
            end
`endif
         end
         OP_AND: res_c = operand_a & operand_b;
         OP_OR:  res_c = operand_a | operand_b;
         OP_XOR: res_c = operand_a ^ operand_b;
         OP_NOT: res_c = ~operand_a;
         OP_INC: res_c = operand_a + DATA_W'(1);
         OP_DEC: res_c = operand_a - DATA_W'(1);
         default: res_c = '0;
      endcase
   end

   assign zero_c = (res_c == '0) && !dz_c;

`ifdef ALU_PIPE_DIV_EN
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] dvsr, quo, rem, rem_nxt;
   logic [DATA_W:0]   rem_sh;
   logic [CNT_W-1:0]  cnt;
   logic              ge;

   // Restoring step: shift next dividend bit into the remainder, subtract divisor if it fits
   assign rem_sh    = {rem, quo[MSB]};
   assign ge        = rem_sh >= {1'b0, dvsr};
   assign rem_nxt   = ge ? DATA_W'(rem_sh - {1'b0, dvsr}) : rem_sh[DATA_W-1:0];
   assign div_q_nxt = {quo[DATA_W-2:0], ge};
   assign div_done  = (state_q == DIV) && (cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvsr <= '0;
         quo  <= '0;
         rem  <= '0;
         cnt  <= '0;
      end else if (accept && div_go) begin
         dvsr <= operand_b;
         quo  <= operand_a;
         rem  <= '0;
         cnt  <= '0;
      end else if (state_q == DIV) begin
         quo  <= div_q_nxt;
         rem  <= rem_nxt;
         cnt  <= cnt + CNT_W'(1);
      end
   end
`else
   assign div_go    = 1'b0;
   assign div_done  = 1'b0;
   assign div_q_nxt = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && div_go) state_d = DIV;
         DIV:     if (div_done) state_d = HOLD;
         HOLD:    if (out_valid && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         result       <= '0;
         zero_flag    <= 1'b0;
         divided_by_0 <= 1'b0;
         overflow_a   <= 1'b0;
         overflow_s   <= 1'b0;
         overflow_m   <= 1'b0;
         fft_strt     <= 1'b0;
         crypto_en    <= 1'b0;
      end else begin
         // Start pulses follow acceptance only; back-pressure never stretches them
         fft_strt  <= accept && (opcode == OP_FFT);
         crypto_en <= accept && ((opcode == OP_ENC) || (opcode == OP_DCR));
         if (accept && !div_go) begin
            out_valid    <= 1'b1;
            result       <= res_c;
            zero_flag    <= zero_c;
            divided_by_0 <= dz_c;
            overflow_a   <= oa_c;
            overflow_s   <= os_c;
            overflow_m   <= om_c;
         end else if (div_done) begin
            out_valid    <= 1'b1;
            result       <= div_q_nxt;
            zero_flag    <= (div_q_nxt == '0);
            divided_by_0 <= 1'b0;
            overflow_a   <= 1'b0;
            overflow_s   <= 1'b0;
            overflow_m   <= 1'b0;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DATA_W, default 19, operand/result width (>= 8).
REQ-002 Parameter OPC_W, default 5, opcode width (>= 5).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opcode  input  OPC_W  0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not, 8 inc, 9 dec, 24 fft, 25 enc, 26 crypto-dec; all others default.
REQ-008 operand_a, operand_b  input  DATA_W each  operands, two's complement for flag purposes.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  DATA_W  registered result.
REQ-012 zero_flag, divided_by_0, overflow_a, overflow_s, overflow_m  output  1 each  registered flags.
REQ-013 fft_strt, crypto_en  output  1 each  single-cycle start pulses.

Function
REQ-014 A request is accepted on a rising edge where in_valid and in_ready are both 1; operands and opcode are captured then.
REQ-015 in_ready = (state == IDLE) and (not out_valid or out_ready), combinational.
REQ-016 FSM states: IDLE, DIV, HOLD; IDLE->DIV on accepted div with operand_b != 0 (macro on); DIV->HOLD when iteration count reaches DATA_W; HOLD->IDLE when out_valid and out_ready; single-cycle ops stay in IDLE.
REQ-017 Non-div ops and div-by-zero: out_valid rises the cycle after acceptance (latency 1); back-to-back acceptance allowed when out_ready = 1.
REQ-018 Divide: unsigned restoring, one quotient bit per cycle; out_valid rises DATA_W+1 cycles after acceptance; result = floor(a/b), remainder discarded.
REQ-019 Div by zero: result all ones, divided_by_0 = 1, latency 1, no DIV entry.
REQ-020 Add: result = a+b mod 2^DATA_W; overflow_a = signs of a,b equal and result sign differs.
REQ-021 Sub: result = a-b mod 2^DATA_W; overflow_s = signs of a,b differ and result sign differs from a.
REQ-022 Mul: result = low DATA_W bits of unsigned product; overflow_m = 1 if any upper DATA_W bits nonzero.
REQ-023 Inc/dec wrap modulo 2^DATA_W, no overflow flag set; logic ops bitwise; not uses operand_a only.
REQ-024 Opcodes 24/25/26: result 0, out_valid as REQ-017; fft_strt (24) or crypto_en (25, 26) high for exactly the acceptance-following cycle, independent of out_ready.
REQ-025 Flags not defined for the current op are 0; zero_flag = (result == 0) and not divided_by_0.
REQ-026 out_valid held with result and flags stable while out_ready = 0; cleared the cycle after out_ready = 1 unless a new result is loaded.
REQ-027 Unknown opcodes: result 0, zero_flag 1, all other flags 0.

Reset
REQ-028 rst asserted: state IDLE, out_valid 0, result 0, all flags 0, fft_strt 0, crypto_en 0, divider counter/partial remainder 0; any in-flight divide is discarded with no output.
REQ-029 First acceptance possible on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro ALU_PIPE_DIV_EN defined: iterative divider and DIV state per REQ-016/018.
REQ-031 ALU_PIPE_DIV_EN undefined: no divider logic; opcode 3 with operand_b != 0 returns result 0, zero_flag 1, latency 1; div-by-zero behaviour of REQ-019 unchanged; DIV state unreachable.

Verification (DATA_W = 19, macro defined)
REQ-032 add a=0x3FFFF b=0x00001 -> next cycle result 0x40000, overflow_a 1, zero_flag 0.
REQ-033 div a=100 b=7 -> in_ready 0 during divide, out_valid exactly 20 cycles after acceptance, result 14.
REQ-034 div a=5 b=0 -> next cycle result 0x7FFFF, divided_by_0 1, zero_flag 0.
REQ-035 opcode 24 then 25 back-to-back, out_ready 1 -> fft_strt one-cycle pulse, then crypto_en one-cycle pulse, two results of 0 with zero_flag 1.
REQ-036 mul a=0x400 b=0x400 with out_ready 0 for 5 cycles -> result 0, overflow_m 1, held stable; in_ready 0 until out_ready 1.
REQ-037 rst asserted 5 cycles into div 100/7 -> outputs 0 immediately, no out_valid afterwards, in_ready 1 after release.
